// File: rtl/level_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | level_ctl : screen-exit detection, level switching and reload handshake  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module level_ctl #(
  parameter logic signed [11:0] TOP_EXIT       = 12'sd4,
  parameter logic signed [11:0] BOTTOM_EXIT    = 12'sd705,
  parameter logic        [11:0] TOP_ENTRY      = 12'd8,
  parameter logic        [11:0] BOTTOM_ENTRY   = 12'd640,
  parameter int                 MAX_LEVEL      = 3,
  parameter int                 CONFIRM_FRAMES = 2,
  parameter int                 SETTLE_FRAMES  = 3,
  parameter int                 ACK_TIMEOUT    = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [11:0] char_y_i,
  input  logic        vblnk_i,
  input  logic        load_ack_i,
  output logic [1:0]  level_o,
  output logic        load_req_o,
  output logic [11:0] load_y_o,
  output logic        busy_o,
  output logic        swap_o,
  output logic        ack_err_o
);

  localparam int              ACK_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [1:0]      LEVEL_MAX = 2'(MAX_LEVEL);
  localparam logic [2:0]      CONF_N    = 3'(CONFIRM_FRAMES);
  localparam logic [2:0]      SETTLE_N  = 3'(SETTLE_FRAMES);

  localparam logic [1:0] S_TRACK   = 2'd0;
  localparam logic [1:0] S_CONFIRM = 2'd1;
  localparam logic [1:0] S_SWAP    = 2'd2;
  localparam logic [1:0] S_SETTLE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             dir_up_q, dir_up_d;
  logic [2:0]       frame_cnt_q, frame_cnt_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [1:0]       level_q, level_d;
  logic             load_req_q, load_req_d;
  logic [11:0]      load_y_q, load_y_d;
  logic             busy_q, busy_d;
  logic             swap_q, swap_d;
  logic             ack_err_q, ack_err_d;
  logic             vblnk_q, vblnk_dly_q;

  logic frame_smp;
  logic exit_up;
  logic exit_dn;
  logic same_dir;
  logic [2:0] frame_cnt_inc;

  assign frame_smp     = vblnk_q & ~vblnk_dly_q;
  assign exit_up       = ($signed(char_y_i) < TOP_EXIT) && (level_q < LEVEL_MAX);
  // Up has priority should a parameter set ever make both exits overlap.
  assign exit_dn       = ($signed(char_y_i) > BOTTOM_EXIT) && (level_q != 2'd0) && !exit_up;
  assign same_dir      = dir_up_q ? exit_up : exit_dn;
  assign frame_cnt_inc = (frame_cnt_q == 3'd7) ? frame_cnt_q : frame_cnt_q + 3'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_TRACK;
      dir_up_q    <= 1'b0;
      frame_cnt_q <= 3'd0;
      ack_cnt_q   <= '0;
      level_q     <= 2'd0;
      load_req_q  <= 1'b0;
      load_y_q    <= 12'd0;
      busy_q      <= 1'b0;
      swap_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      vblnk_q     <= 1'b0;
      vblnk_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_up_q    <= dir_up_d;
      frame_cnt_q <= frame_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      level_q     <= level_d;
      load_req_q  <= load_req_d;
      load_y_q    <= load_y_d;
      busy_q      <= busy_d;
      swap_q      <= swap_d;
      ack_err_q   <= ack_err_d;
      vblnk_q     <= vblnk_i;
      vblnk_dly_q <= vblnk_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_up_d    = dir_up_q;
    frame_cnt_d = frame_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    case (state_q)
      S_TRACK: begin
        if (frame_smp && (exit_up || exit_dn)) begin
          state_d     = S_CONFIRM;
          dir_up_d    = exit_up;
          frame_cnt_d = 3'd1;
        end
      end
      S_CONFIRM: begin
        if (frame_cnt_q >= CONF_N) begin
          state_d   = S_SWAP;
          ack_cnt_d = '0;
        end else if (frame_smp) begin
          if (same_dir) begin
            frame_cnt_d = frame_cnt_inc;
          end else begin
            state_d     = S_TRACK;
            frame_cnt_d = 3'd0;
          end
        end
      end
      S_SWAP: begin
        if (load_ack_i || (ack_cnt_q == ACK_LAST)) begin
          state_d     = S_SETTLE;
          frame_cnt_d = 3'd0;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (frame_cnt_q >= SETTLE_N) begin
          state_d     = S_TRACK;
          frame_cnt_d = 3'd0;
        end else if (frame_smp) begin
          frame_cnt_d = frame_cnt_inc;
        end
      end
      default: begin
        state_d     = S_TRACK;
        frame_cnt_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    level_d    = level_q;
    load_req_d = load_req_q;
    load_y_d   = load_y_q;
    swap_d     = 1'b0;
    ack_err_d  = ack_err_q;
    busy_d     = (state_d == S_SWAP) || (state_d == S_SETTLE);
    if (state_q == S_CONFIRM && state_d == S_SWAP) begin
      level_d    = dir_up_q ? level_q + 2'd1 : level_q - 2'd1;
      load_y_d   = dir_up_q ? BOTTOM_ENTRY : TOP_ENTRY;
      load_req_d = 1'b1;
      swap_d     = 1'b1;
    end
    // Leaving SWAP without an ack can only mean the handshake timed out.
    if (state_q == S_SWAP && state_d == S_SETTLE) begin
      load_req_d = 1'b0;
      if (!load_ack_i) begin
        ack_err_d = 1'b1;
      end
    end
  end

  assign level_o    = level_q;
  assign load_req_o = load_req_q;
  assign load_y_o   = load_y_q;
  assign busy_o     = busy_q;
  assign swap_o     = swap_q;
  assign ack_err_o  = ack_err_q;

endmodule
`default_nettype wire

// File: doc/level_ctl.md
LEVEL_CTL -- requirements
Module: level_ctl

Interface
REQ-001 Parameter TOP_EXIT, default 12'sd4: signed char_y below this is an upward screen exit.
REQ-002 Parameter BOTTOM_EXIT, default 12'sd705: signed char_y above this is a downward screen exit.
REQ-003 Parameter TOP_ENTRY, default 12'd8: load_y after a downward level change.
REQ-004 Parameter BOTTOM_ENTRY, default 12'd640: load_y after an upward level change.
REQ-005 Parameter MAX_LEVEL, default 3: highest level index.
REQ-006 Parameter CONFIRM_FRAMES, default 2: number of consecutive frame samples that must show the same exit.
REQ-007 Parameter SETTLE_FRAMES, default 3: frames held in busy after a reload.
REQ-008 Parameter ACK_TIMEOUT, default 1024: clock cycles to wait for load_ack.
REQ-009 clk  in  1  system clock; all state changes on its rising edge.
REQ-010 rst_n  in  1  asynchronous, active-low reset.
REQ-011 char_y  in  12  character top y from the motion controller, interpreted as signed.
REQ-012 vblnk  in  1  vertical blanking from the VGA timing chain.
REQ-013 load_ack  in  1  the motion controller has accepted load_y.
REQ-014 level  out  2  current level index.
REQ-015 load_req  out  1  request for the motion controller to reposition the character.
REQ-016 load_y  out  12  new character y; valid while load_req=1.
REQ-017 busy  out  1  physics freeze request.
REQ-018 swap  out  1  single-cycle pulse on each level change.
REQ-019 ack_err  out  1  sticky load-handshake timeout flag.

Function
REQ-020 A frame sample occurs on the cycle after a 0->1 transition of registered vblnk; char_y is sampled only at a frame sample.
REQ-021 exit_up = (signed char_y < TOP_EXIT) and level < MAX_LEVEL.
REQ-022 exit_dn = (signed char_y > BOTTOM_EXIT) and level > 0.
REQ-023 exit_up and exit_dn are never true together for legal parameters; if both are true, exit_up wins.
REQ-024 States are TRACK, CONFIRM, SWAP, SETTLE; the reset state is TRACK.
REQ-025 TRACK: a frame sample with an exit -> CONFIRM, storing the direction and setting frame_cnt=1; otherwise remain in TRACK.
REQ-026 CONFIRM, frame sample with the same direction: frame_cnt increments.
REQ-027 CONFIRM: when frame_cnt reaches CONFIRM_FRAMES, go to SWAP.
REQ-028 CONFIRM, frame sample with no exit or the opposite direction: return to TRACK and clear frame_cnt.
REQ-029 SWAP entry cycle: level increments on up or decrements on down, and swap pulses for exactly 1 cycle.
REQ-030 SWAP entry cycle: load_y is set to BOTTOM_ENTRY on up or TOP_ENTRY on down.
REQ-031 SWAP entry cycle: load_req rises, and ack_cnt clears.
REQ-032 SWAP: load_req and load_y hold stable until the first cycle load_ack=1 is sampled.
REQ-033 SWAP: on that cycle, load_req drops on the next edge and the FSM goes to SETTLE with frame_cnt=0.
REQ-034 SWAP: load_ack arriving on the same cycle load_req rises is accepted.
REQ-035 SWAP: ack_cnt counts cycles; when it reaches ACK_TIMEOUT-1 without an ack, ack_err sets, load_req drops and the FSM goes to SETTLE.
REQ-036 A timeout leaves the level change in place.
REQ-037 SETTLE: each frame sample increments frame_cnt; when frame_cnt reaches SETTLE_FRAMES, return to TRACK.
REQ-038 busy=1 in SWAP and SETTLE, and 0 otherwise.
REQ-039 level never leaves the range 0..MAX_LEVEL; an exit at a boundary level is ignored (see REQ-021, REQ-022).
REQ-040 load_ack outside SWAP is ignored.
REQ-041 Only rst_n clears ack_err.
REQ-042 frame_cnt is 3 bits and saturates.
REQ-043 ack_cnt is clog2(ACK_TIMEOUT) bits and does not wrap.
REQ-044 All outputs are registered.

Reset
REQ-045 rst_n=0 asynchronously forces the following, regardless of the current state, including mid-SWAP:
- state=TRACK, level=0, load_req=0, load_y=0
- busy=0, swap=0, ack_err=0
- frame_cnt=0, ack_cnt=0, registered vblnk=0
REQ-046 After rst_n rises, the first frame sample requires a fresh vblnk 0->1 transition.

Verification
REQ-047 level=0; char_y=-3 for 2 frames; ack returned 5 cycles after load_req -> level=1, swap one pulse, load_y=640, busy set for SWAP plus 3 frames.
REQ-048 level=1; char_y=710 for 1 frame, then 300 -> no swap, and the FSM returns to TRACK.
REQ-049 level=3; char_y=0 for 4 frames -> no transition, busy stays 0.
REQ-050 level=2; char_y=720 for 2 frames; load_ack never asserted -> at cycle 1023 ack_err=1 and load_req=0, level=1, then SETTLE, then TRACK.
REQ-051 Frame 1 exit_up, frame 2 exit_dn -> back to TRACK, level unchanged.
REQ-052 rst_n pulled low while load_req=1 -> all outputs reset immediately without waiting for a clock edge; a late load_ack after reset is ignored.
